// File: rtl/uart_word_tx.sv
// Serialises one W_IN-bit result word as a run of back-to-back UART frames, least-significant byte first.
// Optional even-parity bit per frame when UART_WORD_TX_PARITY_EN is defined.
module uart_word_tx #(
    parameter int unsigned CLOCKS_PER_PULSE = 200_000_000 / 9600,
    parameter int unsigned BITS_PER_WORD    = 8,
    parameter int unsigned STOP_BITS        = 4,
    parameter int unsigned W_IN             = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W_IN-1:0] s_data,
    output logic            tx,
    output logic            busy
);

`ifdef UART_WORD_TX_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    localparam int unsigned NUM_WORDS   = W_IN / BITS_PER_WORD;
    localparam int unsigned PACKET_SIZE = 1 + BITS_PER_WORD + STOP_BITS + PARITY_BITS;
    localparam int unsigned CLK_W       = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int unsigned BIT_W       = $clog2(PACKET_SIZE);
    localparam int unsigned BYTE_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    if (W_IN == 0 || (W_IN % BITS_PER_WORD) != 0) begin : g_bad_w_in
        $error("uart_word_tx: W_IN must be a non-zero multiple of BITS_PER_WORD");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                     state_q, state_d;
    logic [CLK_W-1:0]           clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]          byte_cnt_q, byte_cnt_d;
    logic [W_IN-1:0]            shreg_q, shreg_d;
    logic                       tx_d;
    logic                       s_ready_d;
    logic                       busy_d;

    // Line level for frame position idx: start, data LSB first, optional parity, then stop ones.
    function automatic logic frame_bit(input logic [BIT_W-1:0] idx,
                                       input logic [BITS_PER_WORD-1:0] data);
        logic b;
        b = 1'b1;
        if (idx == '0) begin
            b = 1'b0;
        end
        for (int i = 0; i < int'(BITS_PER_WORD); i++) begin
            if (int'(idx) == i + 1) begin
                b = data[i];
            end
        end
`ifdef UART_WORD_TX_PARITY_EN
        if (int'(idx) == int'(BITS_PER_WORD) + 1) begin
            b = ^data;
        end
`endif
        return b;
    endfunction

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            tx         <= 1'b1;
            s_ready    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            tx         <= tx_d;
            s_ready    <= s_ready_d;
            busy       <= busy_d;
        end
    end

    // Next state; tx_d is the level for the cycle after this edge.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        tx_d       = tx;
        s_ready_d  = s_ready;
        busy_d     = busy;

        case (state_q)
            IDLE: begin
                tx_d       = 1'b1;
                s_ready_d  = 1'b1;
                busy_d     = 1'b0;
                clk_cnt_d  = '0;
                bit_cnt_d  = '0;
                byte_cnt_d = '0;
                if (s_valid && s_ready) begin
                    shreg_d   = s_data;
                    state_d   = SEND;
                    s_ready_d = 1'b0;
                    busy_d    = 1'b1;
                    tx_d      = 1'b0;
                end
            end
            SEND: begin
                if (clk_cnt_q != CLK_W'(CLOCKS_PER_PULSE - 1)) begin
                    clk_cnt_d = clk_cnt_q + CLK_W'(1);
                end else begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q != BIT_W'(PACKET_SIZE - 1)) begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        tx_d      = frame_bit(bit_cnt_q + BIT_W'(1), shreg_q[BITS_PER_WORD-1:0]);
                    end else if (byte_cnt_q != BYTE_W'(NUM_WORDS - 1)) begin
                        // Next byte starts immediately: no idle gap between frames.
                        bit_cnt_d  = '0;
                        byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        shreg_d    = shreg_q >> BITS_PER_WORD;
                        tx_d       = 1'b0;
                    end else begin
                        state_d    = IDLE;
                        bit_cnt_d  = '0;
                        byte_cnt_d = '0;
                        tx_d       = 1'b1;
                        s_ready_d  = 1'b1;
                        busy_d     = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with CLOCKS_PER_PULSE=4, 8-bit frames, 1 stop bit, 16-bit words.
// Parity expectations follow UART_WORD_TX_PARITY_EN.
module tb_uart_word_tx;

    localparam int unsigned CPP  = 4;
    localparam int unsigned BPW  = 8;
    localparam int unsigned STOP = 1;
    localparam int unsigned WIN  = 16;
`ifdef UART_WORD_TX_PARITY_EN
    localparam int unsigned PKT  = 11;
`else
    localparam int unsigned PKT  = 10;
`endif

    logic            clk;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [WIN-1:0]  s_data;
    logic            tx;
    logic            busy;

    int n_cmp;
    int n_err;

    uart_word_tx #(
        .CLOCKS_PER_PULSE (CPP),
        .BITS_PER_WORD    (BPW),
        .STOP_BITS        (STOP),
        .W_IN             (WIN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .tx      (tx),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d]: observed %b expected %b", tag, idx, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tx"}, 0, tx, 1'b1);
        chk({tag, "_ready"}, 0, s_ready, 1'b1);
        chk({tag, "_busy"}, 0, busy, 1'b0);
    endtask

    // Called on the first cycle after the handshake; walks every cycle of both frames.
    task automatic check_word(input string tag, input logic [WIN-1:0] w);
        logic [WIN-1:0] rem;
        logic [15:0]    fr;
        logic [7:0]     b;
        rem = w;
        for (int k = 0; k < 2; k++) begin
            b      = rem[7:0];
            rem    = rem >> 8;
            fr     = '1;
            fr[0]  = 1'b0;
            fr[8:1] = b;
`ifdef UART_WORD_TX_PARITY_EN
            fr[9]  = ^b;
`endif
            for (int i = 0; i < int'(PKT); i++) begin
                for (int c = 0; c < int'(CPP); c++) begin
                    chk({tag, "_tx"}, (k * int'(PKT) + i) * int'(CPP) + c, tx, fr[0]);
                    chk({tag, "_ready"}, (k * int'(PKT) + i) * int'(CPP) + c, s_ready, 1'b0);
                    chk({tag, "_busy"}, (k * int'(PKT) + i) * int'(CPP) + c, busy, 1'b1);
                    step();
                end
                fr = fr >> 1;
            end
        end
        chk_idle({tag, "_done"});
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h1111;

        // Reset held 3 cycles with s_valid high: no handshake.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("reset");
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        step();
        chk_idle("post_reset");

        // Single word, s_valid pulsed for one cycle.
        s_data  = 16'hA55A;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        s_data  = 16'h0000;
        check_word("single", 16'hA55A);
        step();
        chk_idle("single_idle");

        // Back-to-back with s_valid held: second word taken in the first idle cycle.
        s_data  = 16'h00FF;
        s_valid = 1'b1;
        step();
        s_data  = 16'h1234;
        check_word("b2b_0", 16'h00FF);
        step();
        s_valid = 1'b0;
        check_word("b2b_1", 16'h1234);
        step();
        chk_idle("b2b_idle");

        // s_data changes mid-transfer; captured word must be sent unchanged.
        s_data  = 16'hC3A5;
        s_valid = 1'b1;
        step();
        s_data  = 16'hFFFF;
        check_word("bp", 16'hC3A5);
        s_valid = 1'b0;
        step();
        chk_idle("bp_idle");

        // Reset during the third data bit of byte 0 (0x9A, bit2 = 0).
        s_data  = 16'h3C9A;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        for (int i = 0; i < 13; i++) begin
            step();
        end
        chk("mid_tx_before", 0, tx, 1'b0);
        chk("mid_busy_before", 0, busy, 1'b1);
        rst = 1'b1;
        step();
        chk_idle("mid_reset");
        rst = 1'b0;
        step();
        chk_idle("mid_release");
        s_data  = 16'h7E81;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        check_word("after_reset", 16'h7E81);

        // Parity-sensitive pattern: 0x07 has odd weight, 0x03 even.
        step();
        s_data  = 16'h0307;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        check_word("par", 16'h0307);
        step();
        chk_idle("final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Downstream stage of the matrix-vector multiplier output path.
- Accepts one wide result word through a valid/ready handshake.
- Splits the word into BITS_PER_WORD-sized bytes and transmits each byte as a UART frame on a single serial line, starting with the least-significant byte.
- Holds off the upstream stage with s_ready until every byte has been sent.

Parameters:
- CLOCKS_PER_PULSE, 200_000_000/9600: clock cycles per serial bit.
- BITS_PER_WORD, 8: data bits per UART frame.
- STOP_BITS, 4: number of stop bits (line high) per frame.
- W_IN, 256: input word width. Must be a non-zero multiple of BITS_PER_WORD; violation is an elaboration error.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- s_valid, input, 1: upstream word valid.
- s_ready, output, 1: block can accept a word.
- s_data, input, W_IN: word to transmit; byte k = s_data[8k+7:8k] for BITS_PER_WORD=8.
- tx, output, 1: serial line; idle level is 1.
- busy, output, 1: high while a word is being shifted out.

Behaviour:
- Derived constants:
  - NUM_WORDS = W_IN/BITS_PER_WORD.
  - PACKET_SIZE = 1 + BITS_PER_WORD + STOP_BITS (+1 when parity is compiled in).
- Reset values: tx=1, s_ready=1, busy=0, state=IDLE, all counters 0.
- Reset has priority. While rst is high, no handshake is taken regardless of s_valid.
- Reset mid-frame aborts the transfer immediately: tx=1 on the next cycle and the captured word is discarded.
- IDLE state:
  - s_ready=1, busy=0, tx=1.
  - Handshake when s_valid && s_ready on a clock edge: latch s_data into a shift register, then s_ready->0, busy->1, state->SEND.
- SEND state:
  - The frame for the current byte is: start bit (0), data bits LSB first, optional parity bit, STOP_BITS ones.
  - Each frame bit drives tx for exactly CLOCKS_PER_PULSE cycles.
  - The first start bit appears on tx in the cycle after the handshake.
- Counters:
  - Clock counter: 0..CLOCKS_PER_PULSE-1.
  - Bit counter: 0..PACKET_SIZE-1.
  - Byte counter: 0..NUM_WORDS-1.
  - When the bit counter wraps, the shift register advances by BITS_PER_WORD.
  - Frames are back-to-back with no idle gap between bytes.
- Completion:
  - On the final cycle of the last stop bit of byte NUM_WORDS-1: state->IDLE, s_ready->1, busy->0. tx stays 1.
  - Total tx activity per word = NUM_WORDS*PACKET_SIZE*CLOCKS_PER_PULSE cycles.
- s_data and s_valid are ignored outside IDLE. Changes in s_data after the handshake do not affect transmission.
- A new word may be accepted in the first IDLE cycle. Its start bit then follows the previous stop bit after exactly one idle cycle.
- All outputs are registered; there are no combinational paths from input to output.

Optional Feature:
- Macro: UART_WORD_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the data bits) is inserted between the last data bit and the first stop bit.
  - PACKET_SIZE grows by 1.
- Undefined:
  - No parity bit; the frame is start, data, stop only.

Test Plan (CLOCKS_PER_PULSE=4, BITS_PER_WORD=8, STOP_BITS=1, W_IN=16 unless stated):
- Reset: hold rst high for 3 cycles with s_valid=1 -> tx=1, s_ready=1, busy=0, and no handshake taken.
- Single word: s_data=16'hA55A, s_valid pulsed for 1 cycle ->
  - tx bit sequence, each bit held 4 cycles: 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1.
  - s_ready low for exactly 80 cycles after the handshake.
- Back-to-back: s_valid held high with 16'h00FF then 16'h1234 -> the second handshake occurs on the first cycle s_ready=1. The second start bit begins 1 cycle after the first word's last stop bit. Bytes are sent in order FF,00,34,12.
- Backpressure: change s_data to 16'hFFFF mid-transfer with s_valid=1 -> the transmitted bytes remain those of the originally captured word, and no extra handshake occurs.
- Reset mid-frame: assert rst during the 3rd data bit of byte 0 -> tx=1 on the next cycle, s_ready=1 after release, and the next word is transmitted cleanly from its start bit.
- Parity (macro defined): s_data=16'h0307 -> parity bit 1 after byte 0x07 and 0 after byte 0x03. Each frame is 11 bits; s_ready is low for 88 cycles.
